phy_rx_serial_lane: RTL



---
 rtl/phy_rx_serial_lane_if.sv | 21 ++
 rtl/phy_rx_serial_lane.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/phy_rx_serial_lane_if.sv
// Serial RX lane bundle: raw bit stream in, recovered byte, strobe and lock status out.
interface phy_rx_serial_lane_if;
   logic       in_rx_serial;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;

   modport master (
      output in_rx_serial,
      input  data_out,
      input  valid_out,
      input  active
   );

   modport slave (
      input  in_rx_serial,
      output data_out,
      output valid_out,
      output active
   );
endinterface

// File: rtl/phy_rx_serial_lane.sv
// Serial lane deserializer: COMMA-based byte alignment, lock after BC_COUNT aligned COMMAs.
// Optional macro PHY_RX_LOCK_LOSS_EN: drop lock after four consecutive 8'h00/8'hFF bytes.
module phy_rx_serial_lane #(
   parameter int unsigned BC_COUNT  = 4,
   parameter logic [7:0]  COMMA_SYM = 8'hBC,
   parameter logic [7:0]  IDLE_SYM  = 8'h7C
) (
   input  logic                 clk,
   input  logic                 reset,
   phy_rx_serial_lane_if.slave  lane
);
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned HIST_W    = BYTE_W - 1;
   localparam int unsigned BIT_CNT_W = 3;
   localparam int unsigned BC_CNT_W  = 4;
   localparam logic [BC_CNT_W-1:0]  BC_TARGET = BC_CNT_W'(BC_COUNT);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST  = '1;
`ifdef PHY_RX_LOCK_LOSS_EN
   localparam int unsigned STUCK_W = 2;
   localparam logic [STUCK_W-1:0] STUCK_LAST = '1;
`endif

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_LOCKING = 2'd1,
      ST_ACTIVE  = 2'd2
   } state_e;

   state_e               state_q,     state_d;
   // Only the seven most recent bits are ever needed to form the candidate byte.
   logic [HIST_W-1:0]    sr_q,        sr_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
   logic [BC_CNT_W-1:0]  bc_cnt_q,    bc_cnt_d;
   logic [BYTE_W-1:0]    data_out_q,  data_out_d;
   logic                 valid_out_q, valid_out_d;
   logic                 active_q,    active_d;
`ifdef PHY_RX_LOCK_LOSS_EN
   logic [STUCK_W-1:0]   stuck_cnt_q, stuck_cnt_d;
   logic                 is_stuck;
`endif

   logic [BYTE_W-1:0]    cand;
   logic                 is_comma;
   logic                 is_data;
   logic                 boundary;

   // Byte completed by the bit arriving this cycle.
   assign cand     = {sr_q, lane.in_rx_serial};
   assign is_comma = (cand == COMMA_SYM);
   assign is_data  = (cand != COMMA_SYM) && (cand != IDLE_SYM);
   assign boundary = (bit_cnt_q == BIT_LAST);
`ifdef PHY_RX_LOCK_LOSS_EN
   assign is_stuck = (cand == 8'h00) || (cand == 8'hFF);
`endif

   always_comb begin
      state_d     = state_q;
      sr_d        = cand[HIST_W-1:0];
      bit_cnt_d   = bit_cnt_q;
      bc_cnt_d    = bc_cnt_q;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
`ifdef PHY_RX_LOCK_LOSS_EN
      stuck_cnt_d = stuck_cnt_q;
`endif

      unique case (state_q)
         ST_SEARCH: begin
            if (is_comma) begin
               state_d   = (BC_COUNT == 1) ? ST_ACTIVE : ST_LOCKING;
               bit_cnt_d = '0;
               bc_cnt_d  = BC_CNT_W'(1);
            end
         end

         ST_LOCKING: begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (boundary) begin
               if (is_comma) begin
                  bc_cnt_d = bc_cnt_q + BC_CNT_W'(1);
                  if (bc_cnt_d == BC_TARGET) begin
                     state_d = ST_ACTIVE;
                  end
               end else begin
                  state_d   = ST_SEARCH;
                  bc_cnt_d  = '0;
                  bit_cnt_d = '0;
               end
            end
         end

         ST_ACTIVE: begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (boundary) begin
               data_out_d  = cand;
               valid_out_d = is_data;
`ifdef PHY_RX_LOCK_LOSS_EN
               // Fourth stuck-line byte in a row drops lock and is not reported.
               if (is_stuck) begin
                  if (stuck_cnt_q == STUCK_LAST) begin
                     state_d     = ST_SEARCH;
                     bc_cnt_d    = '0;
                     bit_cnt_d   = '0;
                     stuck_cnt_d = '0;
                     data_out_d  = data_out_q;
                     valid_out_d = 1'b0;
                  end else begin
                     stuck_cnt_d = stuck_cnt_q + STUCK_W'(1);
                  end
               end else begin
                  stuck_cnt_d = '0;
               end
`endif
            end
         end

         default: begin
            state_d   = ST_SEARCH;
            bc_cnt_d  = '0;
            bit_cnt_d = '0;
         end
      endcase

      active_d = (state_d == ST_ACTIVE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_SEARCH;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         bc_cnt_q    <= '0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
         active_q    <= 1'b0;
`ifdef PHY_RX_LOCK_LOSS_EN
         stuck_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         bc_cnt_q    <= bc_cnt_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
         active_q    <= active_d;
`ifdef PHY_RX_LOCK_LOSS_EN
         stuck_cnt_q <= stuck_cnt_d;
`endif
      end
   end

   assign lane.data_out  = data_out_q;
   assign lane.valid_out = valid_out_q;
   assign lane.active    = active_q;
endmodule
